// File: rtl/img_read_arbiter.sv
// Per-group round-robin read arbiter for the image BRAM groups, with one
// inflight stage and one return FIFO per requester (conv, misc, save).

module img_read_port #(
   parameter int IMG_GRP_NUM = 3,
   parameter int ROW_PARA    = 4,
   parameter int DATA_W      = 256,
   parameter int FIFO_DEPTH  = 4,
   parameter int GRP_W       = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          grant_i,
   input  logic [GRP_W-1:0]              grp_i,
   input  logic [ROW_PARA-1:0]           bank_en_i,
   input  logic [IMG_GRP_NUM*DATA_W-1:0] read_data_i,
   input  logic                          data_ready_i,
   output logic                          credit_ok_o,
   output logic                          data_valid_o,
   output logic [DATA_W-1:0]             data_o
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BANK_W = DATA_W / ROW_PARA;

   logic                             infl_vld_q, infl_vld_d;
   logic [GRP_W-1:0]                 infl_grp_q, infl_grp_d;
   logic [ROW_PARA-1:0]              infl_ben_q, infl_ben_d;
   logic [PTR_W-1:0]                 wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
   logic                             push, pop;
   logic [DATA_W-1:0]                raw, push_data;

   always_comb begin
      infl_vld_d = grant_i;
      infl_grp_d = grp_i;
      infl_ben_d = bank_en_i;
      raw = '0;
      for (int g = 0; g < IMG_GRP_NUM; g++)
         if (infl_grp_q == GRP_W'(g)) raw = read_data_i[g*DATA_W +: DATA_W];
      // banks that were not enabled return garbage from the BRAM; zero them
      push_data = '0;
      for (int b = 0; b < ROW_PARA; b++)
         if (infl_ben_q[b]) push_data[b*BANK_W +: BANK_W] = raw[b*BANK_W +: BANK_W];
      push   = infl_vld_q;
      pop    = (cnt_q != '0) & data_ready_i;
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) begin
         mem_d[wptr_q] = push_data;
         wptr_d        = wptr_q + PTR_W'(1);
      end
      if (pop) rptr_d = rptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         infl_vld_q <= 1'b0;
         infl_grp_q <= '0;
         infl_ben_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         mem_q      <= '0;
      end else begin
         infl_vld_q <= infl_vld_d;
         infl_grp_q <= infl_grp_d;
         infl_ben_q <= infl_ben_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         mem_q      <= mem_d;
      end
   end

   // a read in flight already owns a slot, so it counts against the FIFO
   assign credit_ok_o  = (cnt_q + CNT_W'(infl_vld_q)) < CNT_W'(FIFO_DEPTH);
   assign data_valid_o = (cnt_q != '0);
   assign data_o       = mem_q[rptr_q];

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (cnt_q != CNT_W'(FIFO_DEPTH)));
endmodule

module img_read_arbiter #(
   parameter int IMG_GRP_NUM     = 3,
   parameter int ROW_PARA        = 4,
   parameter int CHL_PARA        = 8,
   parameter int BANK_ADDR_WIDTH = 12,
   parameter int BANK_UNIT_WIDTH = 8,
   parameter int FIFO_DEPTH      = 4,
   localparam int ADDR_W = ROW_PARA * BANK_ADDR_WIDTH,
   localparam int DATA_W = ROW_PARA * CHL_PARA * BANK_UNIT_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [IMG_GRP_NUM-1:0]          conv_read_group_id_i,
   input  logic [ROW_PARA-1:0]             conv_read_bank_en_i,
   input  logic [ADDR_W-1:0]               conv_read_addr_i,
   output logic                            conv_read_addr_ready_o,
   output logic                            conv_read_data_valid_o,
   output logic [DATA_W-1:0]               conv_read_data_o,
   input  logic                            conv_read_data_ready_i,
   input  logic [IMG_GRP_NUM-1:0]          misc_read_group_id_i,
   input  logic [ROW_PARA-1:0]             misc_read_bank_en_i,
   input  logic [ADDR_W-1:0]               misc_read_addr_i,
   output logic                            misc_read_addr_ready_o,
   output logic                            misc_read_data_valid_o,
   output logic [DATA_W-1:0]               misc_read_data_o,
   input  logic                            misc_read_data_ready_i,
   input  logic [IMG_GRP_NUM-1:0]          save_read_group_id_i,
   input  logic [ROW_PARA-1:0]             save_read_bank_en_i,
   input  logic [ADDR_W-1:0]               save_read_addr_i,
   output logic                            save_read_addr_ready_o,
   output logic                            save_read_data_valid_o,
   output logic [DATA_W-1:0]               save_read_data_o,
   input  logic                            save_read_data_ready_i,
   output logic [IMG_GRP_NUM*ADDR_W-1:0]   read_addr_o,
   output logic [IMG_GRP_NUM*ROW_PARA-1:0] read_bank_en_o,
   input  logic [IMG_GRP_NUM*DATA_W-1:0]   read_data_i
);
   localparam int NP    = 3;
   localparam int GRP_W = (IMG_GRP_NUM > 1) ? $clog2(IMG_GRP_NUM) : 1;

   logic [NP-1:0][IMG_GRP_NUM-1:0]    gid;
   logic [NP-1:0][ROW_PARA-1:0]       ben;
   logic [NP-1:0][ADDR_W-1:0]         addr;
   logic [NP-1:0][GRP_W-1:0]          tgt;
   logic [NP-1:0][DATA_W-1:0]         dout;
   logic [NP-1:0]                     dready, credit_ok, elig, grant, dvalid;
   logic [IMG_GRP_NUM-1:0][1:0]       last_q, last_d;
   logic [IMG_GRP_NUM-1:0][ADDR_W-1:0]   addr_grp;
   logic [IMG_GRP_NUM-1:0][ROW_PARA-1:0] ben_grp;

   assign gid    = {save_read_group_id_i, misc_read_group_id_i, conv_read_group_id_i};
   assign ben    = {save_read_bank_en_i, misc_read_bank_en_i, conv_read_bank_en_i};
   assign addr   = {save_read_addr_i, misc_read_addr_i, conv_read_addr_i};
   assign dready = {save_read_data_ready_i, misc_read_data_ready_i, conv_read_data_ready_i};

   // lowest set group bit wins on a multi-hot id
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         tgt[p] = '0;
         for (int g = IMG_GRP_NUM - 1; g >= 0; g--)
            if (gid[p][g]) tgt[p] = GRP_W'(g);
         elig[p] = rst_n & (|ben[p]) & (|gid[p]) & credit_ok[p];
      end
   end

   always_comb begin
      logic found;
      int   p;
      grant    = '0;
      last_d   = last_q;
      addr_grp = '0;
      ben_grp  = '0;
      for (int g = 0; g < IMG_GRP_NUM; g++) begin
         found = 1'b0;
         for (int k = 0; k < NP; k++) begin
            p = (int'(last_q[g]) + 1 + k) % NP;
            if (!found && elig[p] && tgt[p] == GRP_W'(g)) begin
               found       = 1'b1;
               grant[p]    = 1'b1;
               last_d[g]   = 2'(p);
               addr_grp[g] = addr[p];
               ben_grp[g]  = ben[p];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= {IMG_GRP_NUM{2'd2}};
      else        last_q <= last_d;
   end

   for (genvar p = 0; p < NP; p++) begin : g_port
      img_read_port #(
         .IMG_GRP_NUM(IMG_GRP_NUM), .ROW_PARA(ROW_PARA), .DATA_W(DATA_W),
         .FIFO_DEPTH(FIFO_DEPTH), .GRP_W(GRP_W)
      ) u_port (
         .clk         (clk),
         .rst_n       (rst_n),
         .grant_i     (grant[p]),
         .grp_i       (tgt[p]),
         .bank_en_i   (ben[p]),
         .read_data_i (read_data_i),
         .data_ready_i(dready[p]),
         .credit_ok_o (credit_ok[p]),
         .data_valid_o(dvalid[p]),
         .data_o      (dout[p])
      );
   end

   assign read_addr_o            = addr_grp;
   assign read_bank_en_o         = ben_grp;
   assign conv_read_addr_ready_o = grant[0];
   assign misc_read_addr_ready_o = grant[1];
   assign save_read_addr_ready_o = grant[2];
   assign conv_read_data_valid_o = dvalid[0];
   assign misc_read_data_valid_o = dvalid[1];
   assign save_read_data_valid_o = dvalid[2];
   assign conv_read_data_o       = dout[0];
   assign misc_read_data_o       = dout[1];
   assign save_read_data_o       = dout[2];
endmodule

// File: tb/tb_img_read_arbiter.sv
// Randomized bench for img_read_arbiter against a queue-based reference model.

module tb_img_read_arbiter;
   localparam int GN = 3, RP = 4, CP = 8, BAW = 12, BUW = 8, DEPTH = 4;
   localparam int ADDR_W = RP * BAW;
   localparam int DATA_W = RP * CP * BUW;
   localparam int BANK_W = DATA_W / RP;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [2:0][GN-1:0]     gid;
   logic [2:0][RP-1:0]     ben;
   logic [2:0][ADDR_W-1:0] addr;
   logic [2:0]             dready;
   logic [2:0]             aready, dvalid;
   logic [2:0][DATA_W-1:0] dout;
   logic [GN*ADDR_W-1:0]   rd_addr;
   logic [GN*RP-1:0]       rd_ben;
   logic [GN*DATA_W-1:0]   rdata;

   img_read_arbiter #(
      .IMG_GRP_NUM(GN), .ROW_PARA(RP), .CHL_PARA(CP), .BANK_ADDR_WIDTH(BAW),
      .BANK_UNIT_WIDTH(BUW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .conv_read_group_id_i(gid[0]), .conv_read_bank_en_i(ben[0]), .conv_read_addr_i(addr[0]),
      .conv_read_addr_ready_o(aready[0]), .conv_read_data_valid_o(dvalid[0]),
      .conv_read_data_o(dout[0]), .conv_read_data_ready_i(dready[0]),
      .misc_read_group_id_i(gid[1]), .misc_read_bank_en_i(ben[1]), .misc_read_addr_i(addr[1]),
      .misc_read_addr_ready_o(aready[1]), .misc_read_data_valid_o(dvalid[1]),
      .misc_read_data_o(dout[1]), .misc_read_data_ready_i(dready[1]),
      .save_read_group_id_i(gid[2]), .save_read_bank_en_i(ben[2]), .save_read_addr_i(addr[2]),
      .save_read_addr_ready_o(aready[2]), .save_read_data_valid_o(dvalid[2]),
      .save_read_data_o(dout[2]), .save_read_data_ready_i(dready[2]),
      .read_addr_o(rd_addr), .read_bank_en_o(rd_ben), .read_data_i(rdata)
   );

   int n_pass = 0, n_total = 0;

   task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // reference state: returned words per port, one read in flight per port,
   // and the last port served on each group
   logic [DATA_W-1:0] q [3][$];
   bit                m_iv [3];
   int                m_ig [3];
   logic [RP-1:0]     m_ib [3];
   int                m_last [GN];

   task automatic model_reset();
      for (int p = 0; p < 3; p++) begin
         q[p].delete();
         m_iv[p] = 0;
      end
      for (int g = 0; g < GN; g++) m_last[g] = 2;
   endtask

   task automatic step(input int req_pct, input int r0, input int r1, input int r2,
                       input int mode, input int rst_pct);
      int                   rdy [3];
      int                   tg [3];
      bit                   el [3], gr [3], ev;
      logic [GN*ADDR_W-1:0] ea;
      logic [GN*RP-1:0]     eb;
      logic [DATA_W-1:0]    w, s;
      rdy[0] = r0; rdy[1] = r1; rdy[2] = r2;
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(99) < rst_pct) ? 1'b0 : 1'b1;
      for (int p = 0; p < 3; p++) begin
         case (mode)
            1:       gid[p] = GN'(1 << (GN - 1));
            2:       gid[p] = GN'(1 << (p % GN));
            default: gid[p] = GN'($urandom);
         endcase
         ben[p]    = ($urandom_range(99) < req_pct) ? RP'($urandom_range(15, 1)) : '0;
         addr[p]   = ADDR_W'({$urandom, $urandom});
         dready[p] = ($urandom_range(99) < rdy[p]);
      end
      for (int i = 0; i < GN * DATA_W / 32; i++) rdata[i*32 +: 32] = $urandom;
      #3;
      if (!rst_n) begin
         model_reset();
         for (int p = 0; p < 3; p++) begin
            chk($sformatf("rst_ready%0d", p), DATA_W'(aready[p]), '0);
            chk($sformatf("rst_valid%0d", p), DATA_W'(dvalid[p]), '0);
            chk($sformatf("rst_data%0d", p), dout[p], '0);
         end
         chk("rst_addr_o", DATA_W'(rd_addr), '0);
         chk("rst_ben_o", DATA_W'(rd_ben), '0);
         return;
      end
      ea = '0;
      eb = '0;
      for (int p = 0; p < 3; p++) begin
         tg[p] = -1;
         for (int g = 0; g < GN; g++) if (gid[p][g] && tg[p] < 0) tg[p] = g;
         el[p] = (ben[p] != 0) && (tg[p] >= 0) && (q[p].size() + int'(m_iv[p]) < DEPTH);
         gr[p] = 0;
      end
      for (int g = 0; g < GN; g++) begin
         for (int k = 0; k < 3; k++) begin
            int pp;
            pp = (m_last[g] + 1 + k) % 3;
            if (el[pp] && tg[pp] == g) begin
               gr[pp]    = 1;
               m_last[g] = pp;
               ea[g*ADDR_W +: ADDR_W] = addr[pp];
               eb[g*RP +: RP]         = ben[pp];
               break;
            end
         end
      end
      for (int p = 0; p < 3; p++) begin
         ev = (q[p].size() != 0);
         chk($sformatf("ready%0d", p), DATA_W'(aready[p]), DATA_W'(gr[p]));
         chk($sformatf("valid%0d", p), DATA_W'(dvalid[p]), DATA_W'(ev));
         if (ev) chk($sformatf("data%0d", p), dout[p], q[p][0]);
      end
      chk("addr_o", DATA_W'(rd_addr), DATA_W'(ea));
      chk("ben_o", DATA_W'(rd_ben), DATA_W'(eb));
      for (int p = 0; p < 3; p++) begin
         if (q[p].size() != 0 && dready[p]) void'(q[p].pop_front());
         if (m_iv[p]) begin
            s = rdata[m_ig[p]*DATA_W +: DATA_W];
            w = '0;
            for (int b = 0; b < RP; b++)
               if (m_ib[p][b]) w[b*BANK_W +: BANK_W] = s[b*BANK_W +: BANK_W];
            q[p].push_back(w);
         end
         m_iv[p] = gr[p];
         m_ig[p] = tg[p];
         m_ib[p] = ben[p];
      end
   endtask

   task automatic run(input int n, input int req_pct, input int r0, input int r1, input int r2,
                      input int mode, input int rst_pct);
      for (int i = 0; i < n; i++) step(req_pct, r0, r1, r2, mode, rst_pct);
   endtask

   initial begin
      rst_n  = 1'b0;
      gid    = '0;
      ben    = '0;
      addr   = '0;
      dready = '0;
      rdata  = '0;
      model_reset();
      run(3, 100, 100, 100, 100, 1, 100);   // reset with requests pending
      run(40, 100, 100, 100, 100, 1, 0);    // contention on one group, rotation
      run(400, 70, 60, 60, 60, 0, 0);       // random groups incl. multi-hot and zero id
      run(150, 100, 100, 100, 100, 2, 0);   // each port on its own group
      run(60, 100, 100, 100, 0, 0, 0);      // save backpressured, fills its FIFO
      run(60, 100, 100, 100, 100, 0, 0);    // save drains
      run(30, 100, 0, 0, 0, 2, 0);          // everyone stalled
      for (int r = 0; r < 8; r++) begin
         run(20, 90, 50, 50, 50, 0, 0);
         run($urandom_range(2, 1), 100, 100, 100, 100, 1, 100);  // reset mid-flight
         run(15, 100, 100, 100, 100, 1, 0);
      end
      run(800, 60, 30, 70, 90, 0, 2);       // random with occasional resets
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/img_read_arbiter.md
# img_read_arbiter

Shares the IMG_GRP_NUM image BRAM groups of the memory pool between three read requesters: conv (port 0), misc (port 1) and save (port 2). Each group has its own round-robin arbiter, so different groups can serve different ports in the same cycle. Returned data is masked per bank and queued in a per-port FIFO, which gives each requester a valid/ready data interface with backpressure. The block sits between the requester engines and the packed read side of the image bram_groups (1-cycle registered read latency).

## Interface
- IMG_GRP_NUM, 3, number of image groups
- ROW_PARA, 4, banks per group (IMG_BANK_NUM)
- CHL_PARA, 8, units per bank
- BANK_ADDR_WIDTH, 12, per-bank address width
- BANK_UNIT_WIDTH, 8, unit width
- FIFO_DEPTH, 4, return FIFO entries per port (power of 2, ≥3)
- Derived widths:
  - ADDR_W = ROW_PARA*BANK_ADDR_WIDTH
  - DATA_W = ROW_PARA*CHL_PARA*BANK_UNIT_WIDTH

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- {conv,misc,save}_read_group_id_i  in  IMG_GRP_NUM  one-hot target group
- {conv,misc,save}_read_bank_en_i  in  ROW_PARA  bank enables; nonzero = request
- {conv,misc,save}_read_addr_i  in  ADDR_W  per-bank addresses
- {conv,misc,save}_read_addr_ready_o  out  1  request accepted this cycle
- {conv,misc,save}_read_data_valid_o  out  1  FIFO head valid
- {conv,misc,save}_read_data_o  out  DATA_W  FIFO head data
- {conv,misc,save}_read_data_ready_i  in  1  consumer pops head
- read_addr_o  out  IMG_GRP_NUM*ADDR_W  packed group addresses (group g at slice g)
- read_bank_en_o  out  IMG_GRP_NUM*ROW_PARA  packed group bank enables
- read_data_i  in  IMG_GRP_NUM*DATA_W  packed group read data

## Operation
- Request condition for port p: bank_en ≠ 0 and group_id ≠ 0. If group_id is multi-hot, the lowest set bit selects the group.
- A port is eligible when it requests and occupancy + inflight < FIFO_DEPTH. Pops in the current cycle are not credited.
- Arbitration per group:
  - Round-robin among eligible ports that target that group, searching from (last_grant+1) mod 3.
  - last_grant updates only on a grant.
  - Reset value of last_grant is 2, so conv wins first.
- Grant for port p on group g:
  - addr_ready_o[p] = 1.
  - Group g slice of read_bank_en_o = port bank_en; read_addr_o slice = port addr, both combinational in the same cycle.
  - Groups with no grant drive bank_en 0 and addr 0.
- addr_ready_o is combinational from the requests and state. Requesters must not make their request depend on addr_ready_o.
- Inflight stage, one per port, registered:
  - Fields: valid, group index, bank_en.
  - Next cycle, the indexed read_data_i slice is captured.
  - Banks whose bank_en bit was 0 are forced to zero.
  - The result is pushed into port p's FIFO.
- FIFO:
  - data_valid_o = not empty; data_o = head.
  - Pop when valid_o & ready_i.
  - Push and pop in the same cycle are both performed.
- Overflow cannot happen by construction; any overflow is a bug, and an assertion on push-when-full is required.

## Timing
- Accept at cycle T → BRAM address at T → data on read_data_i at T+1 → FIFO write at the T+1 edge → data_valid_o at T+2 at the earliest.
- Throughput: 1 word/cycle per port under continuous ready, provided no conflict on the target group.
- With FIFO_DEPTH=4 and ready_i held at 0, a port accepts exactly 4 requests, then addr_ready_o stays 0 until a pop.
- Three ports on one group: grants rotate 0,1,2,0,… with one grant per cycle.
- Reset (rst_n low, at any time including mid-transfer):
  - FIFOs, inflight stages and pointers are cleared immediately.
  - All outputs are 0: addr_ready_o, data_valid_o, data_o, read_addr_o, read_bank_en_o.
  - In-progress reads are discarded.
- First grant is possible in the first cycle after rst_n deasserts.

## Test plan
- Single read: conv, group_id=3'b010, bank_en=4'b1111, addr=0x005_004_003_002 at T → read_bank_en_o[7:4]=4'hF at T; read_data_i group1=D at T+1 → conv valid_o=1 with data_o=D at T+2.
- Bank masking: misc bank_en=4'b0101, group 0 returns all 0xFF → misc data_o = banks 0 and 2 = 0xFF, banks 1 and 3 = 0x00.
- Contention: all three ports request group 2 continuously with ready=1 → grants conv,misc,save,conv,misc,save over 6 cycles; each port receives 2 words.
- Parallel groups: conv→g0, misc→g1, save→g2 in the same cycle → all three addr_ready_o=1; each port's data returns at T+2 from its own slice.
- Backpressure: save ready_i=0, continuous requests → exactly 4 accepts, then addr_ready_o=0. Raise ready_i → the 4 words pop in order, and the next accept happens in the same cycle as the first pop +1.
- Reset mid-flight: assert rst_n=0 one cycle after accept with 2 words queued → all valid_o=0 immediately. After release, no stale data appears, and the first conv request is granted ahead of misc.
